pong_game_ctrl: RTL and testbench

//  Game sequencer in front of ball_fsm. Synchronises/debounces raw player inputs into
//  1-cycle pulses, runs the match flow (idle, serve, rally, point pause, game over) and

---
 rtl/pong_game_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pong_game_ctrl
// Purpose : Pong match sequencer: input debounce, match flow, frame-locked ball steps
// Revision: 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
    parameter int unsigned DEB_CYC      = 750000,
    parameter int unsigned BASE_FRAMES  = 4,
    parameter int unsigned MIN_FRAMES   = 1,
    parameter int unsigned HITS_PER_LVL = 4,
    parameter int unsigned MAX_LVL      = 3,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [5:0] raw_in,
    input  logic       l_scored_ev,
    input  logic       r_scored_ev,
    input  logic       paddle_hit,
    input  logic       game_over_in,
    output logic [5:0] pulse_out,
    output logic       ball_step,
    output logic       server,
    output logic [2:0] ctrl_state,
    output logic [1:0] speed_lvl
);

    localparam int unsigned DW = $clog2(DEB_CYC + 1);
    localparam int unsigned FW = $clog2(BASE_FRAMES + 1);
    localparam int unsigned HW = $clog2(HITS_PER_LVL + 1);
    localparam int unsigned PW = $clog2(PAUSE_FRAMES + 1);
    localparam logic [1:0]  C_MAX_LVL = 2'(MAX_LVL);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_RALLY = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Per-bit: 2-flop synchroniser, then a level that only follows a stable input
    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
        logic [1:0]    r_sync;
        logic          r_level;
        logic          r_pulse;
        logic [DW-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync  <= 2'b00;
                r_level <= 1'b0;
                r_pulse <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync  <= {r_sync[0], raw_in[gi]};
                r_pulse <= 1'b0;
                if (r_sync[1] == r_level) begin
                    r_cnt <= '0;
                end else if (32'(r_cnt) == DEB_CYC - 1) begin
                    r_cnt   <= '0;
                    r_level <= r_sync[1];
                    r_pulse <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + DW'(1);
                end
            end
        end

        assign pulse_out[gi] = r_pulse;
    end

    logic w_a_up, w_a_down, w_btn_a, w_b_up, w_b_down, w_btn_b;
    assign w_a_up   = pulse_out[0];
    assign w_a_down = pulse_out[1];
    assign w_btn_a  = pulse_out[2];
    assign w_b_up   = pulse_out[3];
    assign w_b_down = pulse_out[4];
    assign w_btn_b  = pulse_out[5];

    state_t        r_state, n_state;
    logic          r_server, n_server;
    logic [1:0]    r_lvl, n_lvl;
    logic [HW-1:0] r_hit, n_hit;
    logic [FW-1:0] r_frame, n_frame;
    logic [PW-1:0] r_pause, n_pause;
    logic          w_step;
    logic [31:0]   w_period_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_server <= 1'b0;
            r_lvl    <= 2'd0;
            r_hit    <= '0;
            r_frame  <= '0;
            r_pause  <= '0;
        end else begin
            r_state  <= n_state;
            r_server <= n_server;
            r_lvl    <= n_lvl;
            r_hit    <= n_hit;
            r_frame  <= n_frame;
            r_pause  <= n_pause;
        end
    end

    // Frames per step shrinks with level but never drops below the floor
    always_comb begin
        if (32'(r_lvl) + MIN_FRAMES >= BASE_FRAMES) begin
            w_period_m1 = MIN_FRAMES - 1;
        end else begin
            w_period_m1 = BASE_FRAMES - 32'(r_lvl) - 1;
        end
    end

    always_comb begin
        n_state  = r_state;
        n_server = r_server;
        n_lvl    = r_lvl;
        n_hit    = r_hit;
        n_frame  = r_frame;
        n_pause  = r_pause;
        w_step   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_btn_a) begin
                    n_state  = S_SERVE;
                    n_server = 1'b0;
                end else if (w_btn_b) begin
                    n_state  = S_SERVE;
                    n_server = 1'b1;
                end
            end
            S_SERVE: begin
                n_lvl   = 2'd0;
                n_hit   = '0;
                n_frame = '0;
                n_pause = '0;
                if (r_server ? (w_b_up | w_b_down) : (w_a_up | w_a_down)) begin
                    n_state = S_RALLY;
                end
            end
            S_RALLY: begin
                if (paddle_hit) begin
                    if (32'(r_hit) == HITS_PER_LVL - 1) begin
                        n_hit = '0;
                        if (r_lvl != C_MAX_LVL) begin
                            n_lvl = r_lvl + 2'd1;
                        end
                    end else begin
                        n_hit = r_hit + HW'(1);
                    end
                end
                // >= rather than == so a shorter period after a level-up never strands the count
                if (frame_start) begin
                    if (32'(r_frame) >= w_period_m1) begin
                        n_frame = '0;
                        w_step  = ~(l_scored_ev | r_scored_ev);
                    end else begin
                        n_frame = r_frame + FW'(1);
                    end
                end
                if (l_scored_ev) begin
                    n_state  = S_PAUSE;
                    n_server = 1'b1;
                    n_pause  = '0;
                end else if (r_scored_ev) begin
                    n_state  = S_PAUSE;
                    n_server = 1'b0;
                    n_pause  = '0;
                end
            end
            S_PAUSE: begin
                if (frame_start) begin
                    if (32'(r_pause) == PAUSE_FRAMES - 1) begin
                        n_pause = '0;
                        n_state = game_over_in ? S_OVER : S_SERVE;
                    end else begin
                        n_pause = r_pause + PW'(1);
                    end
                end
            end
            S_OVER: begin
                if (w_btn_a | w_btn_b) begin
                    n_state  = S_IDLE;
                    n_server = 1'b0;
                end
            end
            default: n_state = S_IDLE;
        endcase
    end

    assign ball_step  = w_step;
    assign server     = r_server;
    assign ctrl_state = r_state;
    assign speed_lvl  = r_lvl;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pong_game_ctrl
// Purpose : Scoreboard bench for pong_game_ctrl with directed match scenarios
// Revision: 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam logic [1:0] K_PULSE = 2'd0;
    localparam logic [1:0] K_STEP  = 2'd1;
    localparam logic [1:0] K_STATE = 2'd2;
    localparam logic [1:0] K_SNAP  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic [5:0] raw_in = 6'd0;
    logic       l_scored_ev = 1'b0;
    logic       r_scored_ev = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       game_over_in = 1'b0;
    logic [5:0] pulse_out;
    logic       ball_step;
    logic       server;
    logic [2:0] ctrl_state;
    logic [1:0] speed_lvl;

    logic       fen = 1'b0;
    logic       snap_req = 1'b0;
    logic       done = 1'b0;
    int         fcount = 0;
    int         tmo_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];

    pong_game_ctrl #(
        .DEB_CYC(4), .BASE_FRAMES(4), .MIN_FRAMES(1),
        .HITS_PER_LVL(4), .MAX_LVL(3), .PAUSE_FRAMES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .raw_in(raw_in),
        .l_scored_ev(l_scored_ev), .r_scored_ev(r_scored_ev), .paddle_hit(paddle_hit),
        .game_over_in(game_over_in), .pulse_out(pulse_out), .ball_step(ball_step),
        .server(server), .ctrl_state(ctrl_state), .speed_lvl(speed_lvl)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk_snap(input logic [5:0] p, input logic s, input logic sv,
                                            input logic [2:0] st, input logic [1:0] l);
        return {19'd0, p, s, sv, st, l};
    endfunction

    // Frame generator: one pulse every 10 cycles while enabled, frames numbered from 1
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!fen) begin
                phase = 0;
                fcount = 0;
                frame_start = 1'b0;
            end else begin
                phase = phase + 1;
                if (phase == 10) begin
                    phase = 0;
                    fcount = fcount + 1;
                    frame_start = 1'b1;
                end else begin
                    frame_start = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_pulse(input logic [5:0] p);
        q.push_back({K_PULSE, {26'd0, p}});
    endtask

    task automatic exp_step(input int n, input logic [1:0] l);
        q.push_back({K_STEP, 32'(n * 4) + {30'd0, l}});
    endtask

    task automatic exp_state(input logic [2:0] st, input logic sv, input logic [1:0] l);
        q.push_back({K_STATE, {26'd0, st, sv, l}});
    endtask

    task automatic exp_snap(input logic sv, input logic [2:0] st, input logic [1:0] l);
        q.push_back({K_SNAP, pk_snap(6'd0, 1'b0, sv, st, l)});
    endtask

    task automatic press(input logic [5:0] m);
        raw_in = m;
        repeat (8) cyc();
        raw_in = 6'd0;
        repeat (8) cyc();
    endtask

    task automatic snap();
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
    endtask

    task automatic wait_frame(input int n);
        int k;
        k = 0;
        while (!(fcount == n && !frame_start) && k < 300) begin
            cyc();
            k++;
        end
        if (k >= 300) tmo_cnt++;
    endtask

    task automatic hits(input int n);
        paddle_hit = 1'b1;
        repeat (n) cyc();
        paddle_hit = 1'b0;
    endtask

    // Stimulus
    initial begin
        int k;
        #1 rst_n = 1'b0;
        exp_snap(1'b0, 3'd0, 2'd0);
        cyc();
        snap();
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();

        // Short glitch is filtered; a held press yields one pulse
        raw_in = 6'b000001;
        repeat (2) cyc();
        raw_in = 6'd0;
        repeat (10) cyc();
        exp_pulse(6'b000001);
        press(6'b000001);

        // Simultaneous buttons: A wins; non-server input ignored
        exp_pulse(6'b100100);
        exp_state(3'd1, 1'b0, 2'd0);
        press(6'b100100);
        exp_pulse(6'b001000);
        press(6'b001000);
        exp_pulse(6'b000010);
        exp_state(3'd2, 1'b0, 2'd0);
        press(6'b000010);

        // Speed ramp
        exp_step(4, 2'd0);
        exp_step(8, 2'd0);
        fen = 1'b1;
        wait_frame(8);
        hits(4);
        exp_step(11, 2'd1);
        exp_step(14, 2'd1);
        wait_frame(14);
        hits(8);
        exp_step(15, 2'd3);
        exp_step(16, 2'd3);
        exp_step(17, 2'd3);
        wait_frame(17);
        hits(4);
        exp_step(18, 2'd3);
        exp_step(19, 2'd3);
        wait_frame(19);

        // Both scores coincident with a frame: no step, left priority
        exp_state(3'd3, 1'b1, 2'd3);
        exp_state(3'd1, 1'b1, 2'd3);
        k = 0;
        while (!frame_start && k < 50) begin
            cyc();
            k++;
        end
        if (k >= 50) tmo_cnt++;
        l_scored_ev = 1'b1;
        r_scored_ev = 1'b1;
        cyc();
        l_scored_ev = 1'b0;
        r_scored_ev = 1'b0;
        wait_frame(23);
        cyc();
        exp_snap(1'b1, 3'd1, 2'd0);
        snap();

        // Right serves, then a game-ending point
        fen = 1'b0;
        exp_pulse(6'b001000);
        exp_state(3'd2, 1'b1, 2'd0);
        press(6'b001000);
        exp_step(4, 2'd0);
        fen = 1'b1;
        wait_frame(5);
        exp_state(3'd3, 1'b0, 2'd0);
        exp_state(3'd4, 1'b0, 2'd0);
        game_over_in = 1'b1;
        r_scored_ev = 1'b1;
        cyc();
        r_scored_ev = 1'b0;
        wait_frame(8);
        fen = 1'b0;
        exp_pulse(6'b100000);
        exp_state(3'd0, 1'b0, 2'd0);
        press(6'b100000);
        game_over_in = 1'b0;

        // New rally, then asynchronous reset mid-period
        exp_pulse(6'b000100);
        exp_state(3'd1, 1'b0, 2'd0);
        press(6'b000100);
        exp_pulse(6'b000001);
        exp_state(3'd2, 1'b0, 2'd0);
        press(6'b000001);
        exp_step(4, 2'd0);
        fen = 1'b1;
        wait_frame(6);
        exp_state(3'd0, 1'b0, 2'd0);
        exp_snap(1'b0, 3'd0, 2'd0);
        rst_n = 1'b0;
        snap();
        fen = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        done = 1'b1;
    end

    task automatic check(input logic [1:0] k, input logic [31:0] v, input string nm);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event actual=%0d required=none", nm, v);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.v != v) begin
                errors++;
                $display("FAIL %s actual kind=%0d val=%0d required kind=%0d val=%0d",
                         nm, k, v, e.kind, e.v);
            end
        end
    endtask

    // Monitor
    initial begin
        logic [2:0] prev_state;
        prev_state = 3'd0;
        forever begin
            @(negedge clk);
            if (pulse_out != 6'd0) check(K_PULSE, {26'd0, pulse_out}, "pulse");
            if (ball_step) check(K_STEP, 32'(fcount * 4) + {30'd0, speed_lvl}, "ball_step");
            if (ctrl_state != prev_state) check(K_STATE, {26'd0, ctrl_state, server, speed_lvl}, "state");
            prev_state = ctrl_state;
            if (snap_req) check(K_SNAP, pk_snap(pulse_out, ball_step, server, ctrl_state, speed_lvl), "snapshot");
            if (done) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover actual=%0d pending required=0", q.size());
                end
                checks++;
                if (tmo_cnt != 0) begin
                    errors++;
                    $display("FAIL wait_timeout actual=%0d required=0", tmo_cnt);
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

endmodule
`default_nettype wire
